// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, runs the imem req/ready + rvalid handshake,
// and presents if_pc/if_inst/if_valid to IF/ID with stall hold and EX redirect flush.
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        stall,
  output logic [31:0] if_pc,
  output logic [31:0] if_inst,
  output logic        if_valid
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_HOLD,
    S_DROP
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] out_pc_q, out_pc_d;
  logic [31:0] out_inst_q, out_inst_d;
  logic        out_vld_q, out_vld_d;
  logic [31:0] skid_pc_q, skid_pc_d;
  logic [31:0] skid_inst_q, skid_inst_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      pc_q        <= RESET_PC;
      out_pc_q    <= 32'h0;
      out_inst_q  <= NOP_INST;
      out_vld_q   <= 1'b0;
      skid_pc_q   <= 32'h0;
      skid_inst_q <= NOP_INST;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      out_pc_q    <= out_pc_d;
      out_inst_q  <= out_inst_d;
      out_vld_q   <= out_vld_d;
      skid_pc_q   <= skid_pc_d;
      skid_inst_q <= skid_inst_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    out_pc_d    = out_pc_q;
    out_inst_d  = out_inst_q;
    out_vld_d   = out_vld_q;
    skid_pc_d   = skid_pc_q;
    skid_inst_d = skid_inst_q;

    // Consumed output retires to a bubble unless something loads below.
    if (out_vld_q && !stall) begin
      out_vld_d  = 1'b0;
      out_inst_d = NOP_INST;
    end

    unique case (state_q)
      S_IDLE: state_d = S_REQ;
      S_REQ: begin
        if (imem_ready) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (imem_rvalid) begin
          pc_d    = pc_q + 32'd4;
          state_d = S_REQ;
          if (!out_vld_q || !stall) begin
            out_pc_d   = pc_q;
            out_inst_d = imem_rdata;
            out_vld_d  = 1'b1;
          end else begin
            skid_pc_d   = pc_q;
            skid_inst_d = imem_rdata;
            state_d     = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (!stall) begin
          out_pc_d   = skid_pc_q;
          out_inst_d = skid_inst_q;
          out_vld_d  = 1'b1;
          state_d    = S_REQ;
        end
      end
      S_DROP: begin
        if (imem_rvalid) state_d = S_REQ;
      end
      default: state_d = S_IDLE;
    endcase

    // Redirect flushes everything; an in-flight fetch must still be drained.
    if (redirect_valid && state_q != S_IDLE) begin
      pc_d       = redirect_pc & ~32'h3;
      out_vld_d  = 1'b0;
      out_inst_d = NOP_INST;
      unique case (state_q)
        S_WAIT:  state_d = imem_rvalid ? S_REQ : S_DROP;
        S_REQ:   state_d = imem_ready ? S_DROP : S_REQ;
        S_DROP:  state_d = imem_rvalid ? S_REQ : S_DROP;
        default: state_d = S_REQ;
      endcase
    end
  end

  assign imem_req  = (state_q == S_REQ);
  assign imem_addr = pc_q;
  assign if_pc     = out_pc_q;
  assign if_inst   = out_inst_q;
  assign if_valid  = out_vld_q;

endmodule
